// File: rtl/inst_queue_pkg.sv
// Shared defaults for the fetch/decode instruction queue.
// Address/data widths and the bubble encoding shown to decode when the queue is empty.
package inst_queue_pkg;

    localparam int unsigned IQ_ADDR_WIDTH = 32;
    localparam int unsigned IQ_DATA_WIDTH = 32;
    localparam logic [31:0] IQ_NOP_INST   = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
// Latency: write visible after the writing edge; read is combinational.
// Backpressure: none, the owner decides when to write.
module sync_fifo_mem #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Storage is intentionally unreset; the owner never exposes an unwritten slot.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction FIFO with jump/interrupt flush and NOP bubble when empty.
// Latency: 1 cycle push-to-head; one push and one pop per cycle sustained.
// Backpressure: inst_ready_o is registered-only (full blocks push even if decode pops that cycle).
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = IQ_ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH = IQ_DATA_WIDTH,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] NOP_INST   = DATA_WIDTH'(IQ_NOP_INST)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_jump_i,
    input  logic                        flush_int_i,
    input  logic                        inst_valid_i,
    input  logic [ADDR_WIDTH-1:0]       inst_addr_i,
    input  logic [DATA_WIDTH-1:0]       inst_i,
    output logic                        inst_ready_o,
    output logic                        inst_valid_o,
    output logic [ADDR_WIDTH-1:0]       inst_addr_o,
    output logic [DATA_WIDTH-1:0]       inst_o,
    input  logic                        id_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]  count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = ADDR_WIDTH + DATA_WIDTH;

    logic             flush;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [ENT_W-1:0] head_dat;

    assign flush        = flush_jump_i | flush_int_i;
    assign inst_ready_o = (count_q != CNT_W'(DEPTH));
    assign inst_valid_o = (count_q != '0);
    assign push         = inst_valid_i & inst_ready_o & ~flush;
    assign pop          = inst_valid_o & id_ready_i & ~flush;
    assign count_o      = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (ENT_W),
        .AW    (PTR_W)
    ) u_mem (
        .clk_i (clk_i),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({inst_addr_i, inst_i}),
        .raddr (rd_ptr),
        .rdata (head_dat)
    );

    // Empty forcing keeps stale storage from ever reaching decode.
    assign inst_addr_o = inst_valid_o ? head_dat[ENT_W-1:DATA_WIDTH] : '0;
    assign inst_o      = inst_valid_o ? head_dat[DATA_WIDTH-1:0]     : NOP_INST;

endmodule

// File: tb/tb_inst_queue.sv
// Directed vector bench for inst_queue: table of single-cycle vectors plus hand sequences.
module tb_inst_queue;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] SALT = 32'hABCD_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_j, flush_i, vld_in, id_rdy;
    logic [31:0] addr_in, data_in;
    logic        rdy_out, vld_out;
    logic [31:0] addr_out, inst_out;
    logic [2:0]  cnt_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inst_queue #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .NOP_INST   (32'h0000_0013)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_jump_i (flush_j),
        .flush_int_i  (flush_i),
        .inst_valid_i (vld_in),
        .inst_addr_i  (addr_in),
        .inst_i       (data_in),
        .inst_ready_o (rdy_out),
        .inst_valid_o (vld_out),
        .inst_addr_o  (addr_out),
        .inst_o       (inst_out),
        .id_ready_i   (id_rdy),
        .count_o      (cnt_out)
    );

    typedef struct {
        logic        fj;
        logic        fi;
        logic        vld;
        logic [31:0] addr;
        logic        idr;
        logic        e_vld;
        logic        e_rdy;
        logic [31:0] e_addr;
        int          e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic fj, logic fi, logic vld, logic [31:0] addr, logic idr,
                                logic e_vld, logic e_rdy, logic [31:0] e_addr, int e_cnt);
        vec_t v;
        v.fj = fj; v.fi = fi; v.vld = vld; v.addr = addr; v.idr = idr;
        v.e_vld = e_vld; v.e_rdy = e_rdy; v.e_addr = e_addr; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every output against an expected state; inst_o is implied by the address.
    task automatic chk_all(input string tag, input logic e_vld, input logic e_rdy,
                           input logic [31:0] e_addr, input int e_cnt);
        chk({tag, ".valid"}, 32'(vld_out), 32'(e_vld));
        chk({tag, ".ready"}, 32'(rdy_out), 32'(e_rdy));
        chk({tag, ".addr"},  addr_out, e_vld ? e_addr : 32'h0);
        chk({tag, ".inst"},  inst_out, e_vld ? (e_addr ^ SALT) : NOP);
        chk({tag, ".count"}, 32'(cnt_out), 32'(e_cnt));
    endtask

    task automatic drive(input logic fj, input logic fi, input logic vld,
                         input logic [31:0] addr, input logic idr);
        flush_j = fj;
        flush_i = fi;
        vld_in  = vld;
        addr_in = addr;
        data_in = addr ^ SALT;
        id_rdy  = idr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] model[$];
        logic [31:0] nxt;

        rst_n = 1'b0;
        drive(0, 0, 0, 32'h0, 0);
        #2;
        chk_all("reset_async", 0, 1, 32'h0, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk_all("idle", 0, 1, 32'h0, 0);

        // fill/refuse/drain, then flush_jump and flush_int each with a same-cycle push
        tbl.push_back(mk(0, 0, 1, 32'h100, 0, 1, 1, 32'h100, 1));
        tbl.push_back(mk(0, 0, 1, 32'h104, 0, 1, 1, 32'h100, 2));
        tbl.push_back(mk(0, 0, 1, 32'h108, 0, 1, 1, 32'h100, 3));
        tbl.push_back(mk(0, 0, 1, 32'h10C, 0, 1, 0, 32'h100, 4));
        tbl.push_back(mk(0, 0, 1, 32'h110, 0, 1, 0, 32'h100, 4));
        tbl.push_back(mk(0, 0, 1, 32'h110, 1, 1, 1, 32'h104, 3));
        tbl.push_back(mk(0, 0, 1, 32'h110, 1, 1, 1, 32'h108, 3));
        tbl.push_back(mk(0, 0, 0, 32'h0,   1, 1, 1, 32'h10C, 2));
        tbl.push_back(mk(0, 0, 0, 32'h0,   1, 1, 1, 32'h110, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0,   1, 0, 1, 32'h0,   0));
        tbl.push_back(mk(0, 0, 0, 32'h0,   1, 0, 1, 32'h0,   0));
        tbl.push_back(mk(0, 0, 1, 32'h1F0, 0, 1, 1, 32'h1F0, 1));
        tbl.push_back(mk(0, 0, 1, 32'h1F4, 0, 1, 1, 32'h1F0, 2));
        tbl.push_back(mk(0, 0, 1, 32'h1F8, 0, 1, 1, 32'h1F0, 3));
        tbl.push_back(mk(1, 0, 1, 32'h200, 0, 0, 1, 32'h0,   0));
        tbl.push_back(mk(0, 0, 1, 32'h300, 0, 1, 1, 32'h300, 1));
        tbl.push_back(mk(0, 0, 1, 32'h304, 0, 1, 1, 32'h300, 2));
        tbl.push_back(mk(0, 0, 1, 32'h308, 0, 1, 1, 32'h300, 3));
        tbl.push_back(mk(0, 1, 1, 32'h30C, 1, 0, 1, 32'h0,   0));
        tbl.push_back(mk(0, 0, 1, 32'h400, 0, 1, 1, 32'h400, 1));
        tbl.push_back(mk(1, 1, 0, 32'h0,   1, 0, 1, 32'h0,   0));

        foreach (tbl[i]) begin
            drive(tbl[i].fj, tbl[i].fi, tbl[i].vld, tbl[i].addr, tbl[i].idr);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].e_vld, tbl[i].e_rdy, tbl[i].e_addr, tbl[i].e_cnt);
        end

        // ready must not follow id_ready_i combinationally when full
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 1, 32'h500 + 32'(4 * k), 0);
            step();
        end
        drive(0, 0, 1, 32'h510, 1);
        #1;
        chk("full_ready_comb", 32'(rdy_out), 32'h0);
        drive(1, 0, 0, 32'h0, 0);
        step();
        chk_all("flush_full", 0, 1, 32'h0, 0);

        // steady push+pop at count 2 across 3*DEPTH+ cycles, checked against a model queue
        model.delete();
        nxt = 32'h1000;
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 1, nxt, 0);
            model.push_back(nxt);
            nxt += 4;
            step();
        end
        for (int k = 0; k < 13; k++) begin
            drive(0, 0, 1, nxt, 1);
            model.push_back(nxt);
            void'(model.pop_front());
            nxt += 4;
            step();
            chk_all($sformatf("stream%0d", k), 1, 1, model[0], 2);
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 32'h0, 1);
            void'(model.pop_front());
            step();
            chk_all($sformatf("drain%0d", k), model.size() != 0, 1,
                    (model.size() != 0) ? model[0] : 32'h0, model.size());
        end

        // asynchronous reset mid-cycle at count 3
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 32'h700 + 32'(4 * k), 0);
            step();
        end
        drive(0, 0, 0, 32'h0, 0);
        chk_all("pre_reset", 1, 1, 32'h700, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("mid_reset", 0, 1, 32'h0, 0);
        #1;
        rst_n = 1'b1;
        step();
        chk_all("post_reset", 0, 1, 32'h0, 0);
        drive(0, 0, 1, 32'h800, 0);
        step();
        chk_all("push_after_reset", 1, 1, 32'h800, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
# inst_queue

Parametrised instruction buffer between fetch and decode, replacing the single-entry IF/ID register with a DEPTH-entry FIFO and a valid/ready handshake on both sides. Fetch pushes (address, instruction) pairs. Decode pops them in order. Jump and interrupt flushes discard every held entry. When the queue is empty, decode sees a NOP bubble at address 0.

## Interface
- ADDR_WIDTH, 32: instruction address width.
- DATA_WIDTH, 32: instruction word width.
- DEPTH, 4: number of entries; a power of two, ≥ 2.
- NOP_INST, 32'h0000_0013: word presented on inst_o when empty.
- clk_i  in  1  sole clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_jump_i  in  1  branch/jump redirect; discards all entries.
- flush_int_i  in  1  interrupt entry; same effect as flush_jump_i.
- inst_valid_i  in  1  fetch presents a valid entry.
- inst_addr_i  in  ADDR_WIDTH  address of the pushed instruction.
- inst_i  in  DATA_WIDTH  pushed instruction word.
- inst_ready_o  out  1  queue can accept a push this cycle.
- inst_valid_o  out  1  head entry is valid.
- inst_addr_o  out  ADDR_WIDTH  head address; 0 when empty.
- inst_o  out  DATA_WIDTH  head instruction; NOP_INST when empty.
- id_ready_i  in  1  decode accepts the head this cycle; low means decode is stalled.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Internal state:
  - storage array of DEPTH × (ADDR_WIDTH + DATA_WIDTH);
  - write pointer and read pointer, log2(DEPTH) bits each, wrapping modulo DEPTH;
  - count register.
- push = inst_valid_i & inst_ready_o & ~flush.
- pop = inst_valid_o & id_ready_i & ~flush.
- flush = flush_jump_i | flush_int_i.
- inst_ready_o = (count_o != DEPTH).
  - Registered-only: a pop in the same cycle does not raise ready when full.
  - No combinational path from id_ready_i to inst_ready_o.
- inst_valid_o = (count_o != 0).
- inst_addr_o / inst_o:
  - head entry when valid;
  - forced to 0 / NOP_INST when empty, so stale storage never reaches decode.
- On push: write the entry at the write pointer and increment the write pointer.
- On pop: increment the read pointer.
- Count update:
  - +1 on push only;
  - −1 on pop only;
  - unchanged on simultaneous push and pop.
- Flush, with both flush inputs having equal priority:
  - next edge sets both pointers and count to 0;
  - any push or pop presented in the same cycle is ignored;
  - flush has priority over every other event.
- Empty queue with inst_valid_i high: the entry is written and becomes visible the next cycle. There is no combinational fall-through.
- Full queue with inst_valid_i high: no write and state unchanged; fetch must hold its inputs.
- id_ready_i high while the queue is empty: no effect. Count never goes below 0.

## Timing
- Reset (rst_ni low, asynchronous) sets:
  - pointers = 0, count_o = 0;
  - inst_valid_o = 0, inst_ready_o = 1;
  - inst_addr_o = 0, inst_o = NOP_INST.
  - Storage contents are don't-care.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Push-to-head latency when empty: 1 cycle; an entry pushed at edge N is on the outputs after edge N.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Flush asserted in cycle N: outputs show empty from edge N+1; a push in cycle N+1 is accepted normally.
- Outputs derive from registered state only, plus the empty-forcing mux. No input-to-output combinational path exists.

## Structure
- Shared defines header holds ADDR_WIDTH and DATA_WIDTH defaults and the NOP encoding, used as the defaults of the same-named parameters.
- One natural sub-module, `sync_fifo_mem`: a DEPTH × W register array with one write port and one asynchronous read port. inst_queue owns the pointers, count, flush logic and output forcing.

## Test plan
- Reset, then idle: inst_valid_o = 0, inst_o = 32'h13, inst_addr_o = 0, inst_ready_o = 1, count_o = 0.
- Push 4 entries (addr 0x100, 0x104, 0x108, 0x10C) with id_ready_i = 0:
  - count_o reaches 4 and inst_ready_o drops;
  - a 5th push at 0x110 is refused;
  - then id_ready_i = 1 pops them in order 0x100…0x10C, and 0x110 is accepted once ready returns.
- Simultaneous push and pop at count 2 for 10 cycles: count_o stays 2 and the output addresses follow push order with 2-entry lag.
- flush_jump_i pulse at count 3 with a push of 0x200 in the same cycle: next cycle count_o = 0 and inst_o = NOP, and 0x200 is not held.
- Same check with flush_int_i.
- Pointer wrap-around: 3·DEPTH sustained pushes and pops; the sequence emerges intact with no loss or duplication.
- rst_ni pulled low asynchronously mid-clock at count 3: outputs go to their reset values before the next edge.
